// File: rtl/tl_pkg.sv
// TileLink D-channel types shared by the D-channel routing blocks.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tl_pkg;

  localparam int TL_SIZE_W = 10;
  localparam int TL_SRC_W  = 8;
  localparam int TL_DATA_W = 32;

  // D-channel opcodes (encodings follow the TileLink D channel).
  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1,
    GRANT           = 3'd4,
    GRANT_DATA      = 3'd5,
    RELEASE_ACK     = 3'd6
  } tl_d_op_e;

  // One D beat. size is the number of additional beats in a data burst.
  typedef struct packed {
    tl_d_op_e               opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SRC_W-1:0]    source;
    logic [TL_DATA_W-1:0]   data;
  } tl_d_t;

endpackage

// File: rtl/tl_skid_buf.sv
// Two-entry skid buffer decoupling a valid/ready channel.
// Latency: 1 cycle, full throughput.
// Backpressure: inp_ready_o comes straight from a register (low only while the skid slot is full).
// Ports: clk_i/rst_i (async active-high); inp_* upstream channel; oup_* downstream channel.
module tl_skid_buf #(
  parameter type DATA_T = logic [0:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  inp_valid_i,
  output logic  inp_ready_o,
  input  DATA_T inp_bits_i,
  output logic  oup_valid_o,
  input  logic  oup_ready_i,
  output DATA_T oup_bits_o
);

  DATA_T main_q, skid_q;
  logic  main_vld_q, skid_vld_q;

  assign inp_ready_o = ~skid_vld_q;
  assign oup_valid_o = main_vld_q;
  assign oup_bits_o  = main_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (oup_ready_i || !main_vld_q) begin
      // Output slot drains this cycle: refill from skid first, otherwise from input.
      if (skid_vld_q) begin
        main_q     <= skid_q;
        main_vld_q <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        main_q     <= inp_bits_i;
        main_vld_q <= inp_valid_i;
      end
    end else if (inp_valid_i && !skid_vld_q) begin
      // Output stalled but input was already promised ready: park the beat.
      skid_q     <= inp_bits_i;
      skid_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/tl_router_d.sv
// Routes TileLink D beats from one slave-side port to MASTER_NUM master ports by source index, burst-locked.
// Latency: 0 cycles (combinational); 1 cycle when TL_ROUTER_D_PIPE_EN is defined (skid buffer in front).
// Backpressure: inp_ready_o follows the selected port's ready; unroutable IDLE beats are always accepted and dropped.
// Ports: clk_i, rst_i (async active-high); inp_valid_i/inp_ready_o/inp_bits_i slave side;
//        oup_valid_o/oup_ready_i/oup_bits_o master side (bits broadcast); err_o one-cycle error pulse.
// Config macro: TL_ROUTER_D_PIPE_EN inserts tl_skid_buf between input and routing.
module tl_router_d #(
  parameter int  MASTER_NUM = 2,
  parameter type DATA_T     = logic [0:0],
  parameter int  SRC_SHIFT  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  DATA_T                 inp_bits_i,
  output logic [MASTER_NUM-1:0] oup_valid_o,
  input  logic [MASTER_NUM-1:0] oup_ready_i,
  output DATA_T                 oup_bits_o [MASTER_NUM],
  output logic                  err_o
);
  import tl_pkg::*;

  localparam int IDX_W   = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int COUNT_W = 10;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   lock_q, lock_d;
  logic [COUNT_W-1:0] counter_q, counter_d;

  logic  rt_valid, rt_ready;
  DATA_T rt_bits;

`ifdef TL_ROUTER_D_PIPE_EN
  tl_skid_buf #(.DATA_T(DATA_T)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .inp_bits_i  (inp_bits_i),
    .oup_valid_o (rt_valid),
    .oup_ready_i (rt_ready),
    .oup_bits_o  (rt_bits)
  );
`else
  // Reset gates the valid so outputs are quiet for the whole reset window.
  assign rt_valid    = inp_valid_i & ~rst_i;
  assign rt_bits     = inp_bits_i;
  assign inp_ready_o = rt_ready;
`endif

  tl_d_t              beat;
  logic               unused_beat;
  logic [IDX_W-1:0]   idx, route_idx;
  logic [MASTER_NUM-1:0] sel;
  logic               in_range, drop, hs, burst_op;

  // Field view of the beat; DATA_T is laid out as tl_d_t.
  assign beat        = tl_d_t'(rt_bits);
  assign unused_beat = ^beat;

  assign idx       = beat.source[SRC_SHIFT +: IDX_W];
  assign in_range  = ({1'b0, idx} < (IDX_W+1)'(MASTER_NUM));
  assign route_idx = (state_q == BURST) ? lock_q : idx;
  // Out-of-range index only matters in IDLE; a burst always has a valid lock.
  assign drop      = (state_q == IDLE) && !in_range;
  assign burst_op  = ((beat.opcode == ACCESS_ACK_DATA) || (beat.opcode == GRANT_DATA))
                     && (beat.size != '0);

  always_comb begin
    sel = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (route_idx == IDX_W'(i)) sel[i] = 1'b1;
    end
  end

  // Ready depends on state and the beat's routing only, never on valid.
  assign rt_ready    = drop | (|(oup_ready_i & sel));
  assign hs          = rt_valid & rt_ready;
  assign oup_valid_o = {MASTER_NUM{rt_valid & ~drop}} & sel;
  assign err_o       = hs & (drop | ((state_q == BURST) && (idx != lock_q)));

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) oup_bits_o[i] = rt_bits;
  end

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        if (hs && !drop && burst_op) begin
          state_d   = BURST;
          lock_d    = idx;
          counter_d = beat.size[COUNT_W-1:0];
        end
      end
      BURST: begin
        if (hs) begin
          counter_d = counter_q - COUNT_W'(1);
          if (counter_q == COUNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lock_q    <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      counter_q <= counter_d;
    end
  end

endmodule

// File: tb/tb_tl_router_d.sv
// Directed bench for tl_router_d (default build, no skid buffer).
// Latency: n/a.
// Backpressure: n/a.
module tb_tl_router_d;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in4_vld, in4_rdy, err4;
  tl_d_t       in4_bits;
  logic [3:0]  out4_vld, out4_rdy;
  tl_d_t       out4_bits [4];

  logic        in3_vld, in3_rdy, err3;
  tl_d_t       in3_bits;
  logic [2:0]  out3_vld, out3_rdy;
  tl_d_t       out3_bits [3];

  tl_router_d #(.MASTER_NUM(4), .DATA_T(tl_d_t), .SRC_SHIFT(2)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(in4_vld), .inp_ready_o(in4_rdy), .inp_bits_i(in4_bits),
    .oup_valid_o(out4_vld), .oup_ready_i(out4_rdy), .oup_bits_o(out4_bits),
    .err_o(err4)
  );

  tl_router_d #(.MASTER_NUM(3), .DATA_T(tl_d_t), .SRC_SHIFT(0)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(in3_vld), .inp_ready_o(in3_rdy), .inp_bits_i(in3_bits),
    .oup_valid_o(out3_vld), .oup_ready_i(out3_rdy), .oup_bits_o(out3_bits),
    .err_o(err3)
  );

  logic       st4, st3;
  logic [9:0] cnt4;
  logic [1:0] lk4;
  assign st4  = dut4.state_q;
  assign st3  = dut3.state_q;
  assign cnt4 = dut4.counter_q;
  assign lk4  = dut4.lock_q;

  int total = 0;
  int bad   = 0;

  function automatic tl_d_t mk(tl_d_op_e op, logic [9:0] sz, logic [7:0] src, logic [31:0] dat);
    tl_d_t b;
    b.opcode = op;
    b.size   = sz;
    b.source = src;
    b.data   = dat;
    return b;
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    in4_bits = mk(ACCESS_ACK, 10'd0, 8'h09, 32'h0);
    in4_vld  = 1'b1;
    out4_rdy = 4'b1111;
    in3_bits = mk(ACCESS_ACK, 10'd0, 8'h03, 32'h0);
    in3_vld  = 1'b1;
    out3_rdy = 3'b000;
    #3;
    total++; if (out4_vld !== 4'b0000) begin bad++; $display("FAIL reset_valid4 got=%b exp=0000", out4_vld); end
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL reset_err4 got=%b exp=0", err4); end
    total++; if (out3_vld !== 3'b000) begin bad++; $display("FAIL reset_valid3 got=%b exp=000", out3_vld); end
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL reset_err3 got=%b exp=0", err3); end
    total++; if (st4 !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", st4); end
    total++; if (cnt4 !== 10'd0) begin bad++; $display("FAIL reset_counter got=%0d exp=0", cnt4); end
    total++; if (lk4 !== 2'd0) begin bad++; $display("FAIL reset_lock got=%0d exp=0", lk4); end
    #9;
    rst     = 1'b0;
    in4_vld = 1'b0;
    in3_vld = 1'b0;
  endtask

  task automatic test_single();
    tl_d_t b;
    @(posedge clk); #1;
    b        = mk(ACCESS_ACK, 10'd0, 8'h09, 32'h1111_0001);
    out4_rdy = 4'b1111;
    in4_bits = b;
    in4_vld  = 1'b1;
    #4;
    total++; if (out4_vld !== 4'b0100) begin bad++; $display("FAIL single_valid got=%b exp=0100", out4_vld); end
    total++; if (in4_rdy !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in4_rdy); end
    total++; if (out4_bits[0] !== b || out4_bits[3] !== b) begin
      bad++; $display("FAIL single_broadcast got=%h/%h exp=%h", out4_bits[0], out4_bits[3], b);
    end
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err4); end
    out4_rdy = 4'b1011;
    #1;
    total++; if (in4_rdy !== 1'b0) begin bad++; $display("FAIL single_ready_port got=%b exp=0", in4_rdy); end
    out4_rdy = 4'b1111;
    @(posedge clk); #1;
    in4_vld = 1'b0;
    total++; if (st4 !== 1'b0) begin bad++; $display("FAIL single_state got=%b exp=0", st4); end
  endtask

  task automatic test_burst();
    @(posedge clk); #1;
    out4_rdy = 4'b1111;
    in4_bits = mk(ACCESS_ACK_DATA, 10'd3, 8'h04, 32'h0);
    in4_vld  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in4_bits.data = 32'(i);
      #4;
      total++; if (out4_vld !== 4'b0010) begin bad++; $display("FAIL burst_valid beat=%0d got=%b exp=0010", i, out4_vld); end
      @(posedge clk); #1;
      total++; if (cnt4 !== 10'(3 - i)) begin bad++; $display("FAIL burst_counter beat=%0d got=%0d exp=%0d", i, cnt4, 3 - i); end
      total++; if (st4 !== (i < 3)) begin bad++; $display("FAIL burst_state beat=%0d got=%b exp=%b", i, st4, (i < 3)); end
    end
    in4_vld = 1'b0;
  endtask

  task automatic test_stall();
    int acc  = 0;
    int cyc  = 0;
    int seen = 0;
    logic hs;
    @(posedge clk); #1;
    in4_bits = mk(GRANT_DATA, 10'd3, 8'h08, 32'h0);
    in4_vld  = 1'b1;
    while (acc < 4 && cyc < 20) begin
      out4_rdy      = {1'b1, cyc[0], 2'b11};
      hs            = cyc[0];
      in4_bits.data = 32'(acc);
      #4;
      total++; if (out4_vld !== 4'b0100) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b exp=0100", cyc, out4_vld); end
      total++; if (in4_rdy !== hs) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, in4_rdy, hs); end
      if (out4_vld[2] && in4_rdy) seen++;
      @(posedge clk); #1;
      if (hs) acc++;
      cyc++;
      if (acc >= 1 && acc < 4) begin
        total++; if (lk4 !== 2'd2) begin bad++; $display("FAIL stall_lock cyc=%0d got=%0d exp=2", cyc, lk4); end
        total++; if (st4 !== 1'b1) begin bad++; $display("FAIL stall_state cyc=%0d got=%b exp=1", cyc, st4); end
        total++; if (cnt4 !== 10'(4 - acc)) begin bad++; $display("FAIL stall_counter cyc=%0d got=%0d exp=%0d", cyc, cnt4, 4 - acc); end
      end
    end
    in4_vld  = 1'b0;
    out4_rdy = 4'b1111;
    total++; if (seen !== 4) begin bad++; $display("FAIL stall_beats got=%0d exp=4", seen); end
    total++; if (st4 !== 1'b0) begin bad++; $display("FAIL stall_end_state got=%b exp=0", st4); end
  endtask

  task automatic test_unroutable();
    @(posedge clk); #1;
    out3_rdy = 3'b000;
    in3_bits = mk(ACCESS_ACK, 10'd0, 8'h03, 32'h0);
    in3_vld  = 1'b1;
    #4;
    total++; if (in3_rdy !== 1'b1) begin bad++; $display("FAIL unroute_ready got=%b exp=1", in3_rdy); end
    total++; if (out3_vld !== 3'b000) begin bad++; $display("FAIL unroute_valid got=%b exp=000", out3_vld); end
    total++; if (err3 !== 1'b1) begin bad++; $display("FAIL unroute_err got=%b exp=1", err3); end
    @(posedge clk); #1;
    total++; if (st3 !== 1'b0) begin bad++; $display("FAIL unroute_state got=%b exp=0", st3); end
    in3_bits = mk(ACCESS_ACK, 10'd0, 8'h02, 32'h5);
    out3_rdy = 3'b100;
    #4;
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL unroute_err_next got=%b exp=0", err3); end
    total++; if (out3_vld !== 3'b100) begin bad++; $display("FAIL route3_valid got=%b exp=100", out3_vld); end
    @(posedge clk); #1;
    in3_vld = 1'b0;
  endtask

  task automatic test_mismatch();
    int errs = 0;
    @(posedge clk); #1;
    out4_rdy = 4'b1111;
    in4_vld  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in4_bits = mk(ACCESS_ACK_DATA, 10'd3, (i == 1) ? 8'h08 : 8'h04, 32'(i));
      #4;
      total++; if (out4_vld !== 4'b0010) begin bad++; $display("FAIL mism_valid beat=%0d got=%b exp=0010", i, out4_vld); end
      total++; if (err4 !== (i == 1)) begin bad++; $display("FAIL mism_err beat=%0d got=%b exp=%b", i, err4, (i == 1)); end
      if (err4 === 1'b1) errs++;
      @(posedge clk); #1;
    end
    in4_vld = 1'b0;
    total++; if (errs !== 1) begin bad++; $display("FAIL mism_err_count got=%0d exp=1", errs); end
    total++; if (st4 !== 1'b0) begin bad++; $display("FAIL mism_state got=%b exp=0", st4); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out4_rdy = 4'b1111;
    in4_bits = mk(GRANT_DATA, 10'd3, 8'h0C, 32'h0);
    in4_vld  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (cnt4 !== 10'd2 || lk4 !== 2'd3 || st4 !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=cnt%0d/lk%0d/st%b exp=cnt2/lk3/st1", cnt4, lk4, st4);
    end
    in4_bits.data = 32'd2;
    #1;
    rst = 1'b1;
    #1;
    total++; if (out4_vld !== 4'b0000) begin bad++; $display("FAIL rstmid_valid got=%b exp=0000", out4_vld); end
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err4); end
    total++; if (st4 !== 1'b0 || cnt4 !== 10'd0 || lk4 !== 2'd0) begin
      bad++; $display("FAIL rstmid_state got=st%b/cnt%0d/lk%0d exp=st0/cnt0/lk0", st4, cnt4, lk4);
    end
    #2;
    rst      = 1'b0;
    in4_bits = mk(ACCESS_ACK, 10'd0, 8'h04, 32'h7);
    #2;
    total++; if (out4_vld !== 4'b0010) begin bad++; $display("FAIL rstmid_next_valid got=%b exp=0010", out4_vld); end
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL rstmid_next_err got=%b exp=0", err4); end
    @(posedge clk); #1;
    in4_vld = 1'b0;
    total++; if (st4 !== 1'b0) begin bad++; $display("FAIL rstmid_next_state got=%b exp=0", st4); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_unroutable();
    test_mismatch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_router_d.md
TL_ROUTER_D -- requirements
Module: tl_router_d

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2, the number of master-side D ports (1..16).
REQ-002 SHALL have parameter DATA_T, default logic[0:0], the TileLink D beat type carrying opcode, size and source fields.
REQ-003 SHALL have parameter SRC_SHIFT, default 0, the LSB of the master index within source.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port inp_valid_i / inp_ready_o / inp_bits_i  in/out/in  1/1/DATA_T  slave-side D channel.
REQ-007 SHALL have port oup_valid_o / oup_ready_i / oup_bits_o  out/in/out  [MASTER_NUM]/[MASTER_NUM]/DATA_T[MASTER_NUM]  master-side D channels.
REQ-008 SHALL have port err_o  output  1  one-cycle pulse on an unroutable or mid-burst-mismatched beat.

Function
REQ-009 SHALL compute index idx = source[SRC_SHIFT +: IDX_W], IDX_W = max(1, clog2(MASTER_NUM)).
REQ-010 SHALL, in IDLE, drive oup_valid_o[idx] = inp_valid_i and inp_ready_o = oup_ready_i[idx]; all other oup_valid_o bits are 0.
REQ-011 SHALL broadcast the beat unchanged on every oup_bits_o element; only valid selects the destination.
REQ-012 SHALL use FSM states IDLE and BURST; reset state is IDLE.
REQ-013 SHALL, on a handshake in IDLE with size >= 1 and opcode AccessAckData or GrantData, latch idx into lock_q, load counter_q = size, and go to BURST.
REQ-014 SHALL treat every other opcode, or size == 0, as single-beat and stay in IDLE.
REQ-015 SHALL, in BURST, route to lock_q regardless of the source field, and decrement counter_q on each handshake.
REQ-016 SHALL return to IDLE on the BURST handshake where counter_q == 1, so a burst totals size+1 beats.
REQ-017 SHALL make counter_q 10 bits wide; size values above 1023 are out of scope.
REQ-018 SHALL accept an IDLE beat with idx >= MASTER_NUM with inp_ready_o = 1, drop it, pulse err_o, and leave the FSM in IDLE.
REQ-019 SHALL, in BURST, route a beat whose idx differs from lock_q to lock_q and pulse err_o in the cycle of its handshake.
REQ-020 SHALL hold lock_q and counter_q while a BURST beat stalls (oup_ready_i[lock_q] = 0).
REQ-021 SHALL not combinationally depend inp_ready_o on inp_valid_i, preserving valid/ready independence.

Reset
REQ-022 SHALL, while rst_i = 1, force state = IDLE, counter_q = 0, lock_q = 0, oup_valid_o = 0, err_o = 0, and all pipeline valids = 0.
REQ-023 SHALL discard an in-flight burst on reset mid-burst; the first beat after reset is routed as an IDLE beat.

Configuration
REQ-024 SHALL, with macro TL_ROUTER_D_PIPE_EN defined, insert a two-entry skid buffer between the input and routing logic: one cycle of latency, full throughput, and inp_ready_o driven from a register.
REQ-025 SHALL, without TL_ROUTER_D_PIPE_EN, be combinational from input to output with zero latency.

Structure
REQ-026 SHALL take the D opcode enum (AccessAck, AccessAckData, Grant, GrantData, ReleaseAck) and the beat struct from tl_pkg; no new package types.
REQ-027 SHALL place the skid buffer in sub-module tl_skid_buf (DATA_T parameter), instantiated only under TL_ROUTER_D_PIPE_EN.

Verification
REQ-028 SHALL verify: MASTER_NUM=4, SRC_SHIFT=2, AccessAck with source=0x9 -> oup_valid_o=4'b0100, same-cycle handshake, FSM stays IDLE.
REQ-029 SHALL verify: AccessAckData size=3, source idx 1 -> 4 beats on port 1, state returns to IDLE after beat 4, counter_q sequence 3,2,1,0.
REQ-030 SHALL verify: burst to port 2 with oup_ready_i[2] toggled 0/1 each cycle -> no beat lost or duplicated, lock_q = 2 throughout.
REQ-031 SHALL verify: MASTER_NUM=3, beat with idx=3 -> inp_ready_o = 1, no oup_valid_o, err_o high for exactly 1 cycle.
REQ-032 SHALL verify: beat 2 of a 4-beat burst carries a different source -> delivered to the locked port, err_o pulses once.
REQ-033 SHALL verify: rst_i asserted after beat 2 of a 4-beat burst -> outputs zero immediately (asynchronous), and the next beat, a single-beat AccessAck, routes by its own source.
